ringosc_meas_ctrl: RTL and testbench

RINGOSC_MEAS_CTRL -- requirements
Module: ringosc_meas_ctrl

---
 rtl/ringosc_meas_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_ringosc_meas_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ringosc_meas_ctrl.sv
// Ring-oscillator measurement sequencer: clears the ripple counter, opens a
// gate window of G clk cycles, lets the counter settle, then reads the 64-bit
// count back one byte at a time through the counter's byte-select shifter.
module ringosc_meas_ctrl #(
    parameter int unsigned CLR_CYC    = 2,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned RD_CYC     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] gate_cycles,
    input  logic [7:0]  cnt_byte,
    output logic        cnt_stop,
    output logic        cnt_reset,
    output logic [5:0]  cnt_shift,
    output logic        busy,
    output logic        done,
    output logic        result_valid,
    output logic [63:0] result
);

    localparam int unsigned CYC_W   = 16;
    localparam int unsigned GATE_W  = 16;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned SHIFT_W = 6;
    localparam int unsigned BYTE_W  = 8;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(7);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_SETTLE,
        S_READ,
        S_DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CYC_W-1:0]    cyc_q;      // CLEAR / SETTLE / READ-slot cycle count
    logic [CYC_W-1:0]    cyc_d;
    logic [GATE_W-1:0]   run_q;      // RUN window down-counter
    logic [GATE_W-1:0]   run_d;
    logic [IDX_W-1:0]    idx_q;      // READ byte index
    logic [IDX_W-1:0]    idx_d;
    logic [GATE_W-1:0]   gate_q;     // latched gate length G
    logic [GATE_W-1:0]   gate_d;
    logic                valid_d;
    logic                cap_en;
    logic                stop_d;
    logic                clr_d;
    logic [SHIFT_W-1:0]  shift_d;
    logic                busy_d;
    logic                done_d;

    // Next-state, counter and next-output computation
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        run_d   = run_q;
        idx_d   = idx_q;
        gate_d  = gate_q;
        valid_d = result_valid;
        cap_en  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (abort) begin
                    valid_d = 1'b0;
                end else if (start) begin
                    gate_d  = gate_cycles;
                    valid_d = 1'b0;
                    cyc_d   = CYC_W'(CLR_CYC - 1);
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (cyc_q == '0) begin
                    if (gate_q == '0) begin
                        cyc_d   = CYC_W'(SETTLE_CYC - 1);
                        state_d = S_SETTLE;
                    end else begin
                        run_d   = gate_q - GATE_W'(1);
                        state_d = S_RUN;
                    end
                end else begin
                    cyc_d = cyc_q - CYC_W'(1);
                end
            end
            S_RUN: begin
                if (run_q == '0) begin
                    cyc_d   = CYC_W'(SETTLE_CYC - 1);
                    state_d = S_SETTLE;
                end else begin
                    run_d = run_q - GATE_W'(1);
                end
            end
            S_SETTLE: begin
                if (cyc_q == '0) begin
                    idx_d   = '0;
                    cyc_d   = CYC_W'(RD_CYC - 1);
                    state_d = S_READ;
                end else begin
                    cyc_d = cyc_q - CYC_W'(1);
                end
            end
            S_READ: begin
                if (cyc_q == '0) begin
                    cap_en = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        cyc_d = CYC_W'(RD_CYC - 1);
                    end
                end else begin
                    cyc_d = cyc_q - CYC_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort from any busy state wins over whatever the state wanted
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            cap_en  = 1'b0;
            cyc_d   = '0;
            run_d   = '0;
            idx_d   = '0;
        end

        stop_d  = (state_d != S_RUN);
        clr_d   = (state_d == S_CLEAR);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        shift_d = (state_d == S_READ) ? {idx_d, 3'b000} : '0;
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cyc_q        <= '0;
            run_q        <= '0;
            idx_q        <= '0;
            gate_q       <= '0;
            cnt_stop     <= 1'b1;
            cnt_reset    <= 1'b0;
            cnt_shift    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            run_q        <= run_d;
            idx_q        <= idx_d;
            gate_q       <= gate_d;
            cnt_stop     <= stop_d;
            cnt_reset    <= clr_d;
            cnt_shift    <= shift_d;
            busy         <= busy_d;
            done         <= done_d;
            result_valid <= valid_d;
            if (cap_en) begin
                result[{idx_q, 3'b000} +: BYTE_W] <= cnt_byte;
            end
        end
    end

endmodule

// File: tb/tb_ringosc_meas_ctrl.sv
// Bench for ringosc_meas_ctrl: counter model plus a done-time scoreboard.
module tb_ringosc_meas_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] gate_cycles;
    logic [7:0]  cnt_byte;
    logic        cnt_stop;
    logic        cnt_reset;
    logic [5:0]  cnt_shift;
    logic        busy;
    logic        done;
    logic        result_valid;
    logic [63:0] result;

    typedef struct {
        logic [63:0] res;
        int          done_cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks;
    int          n_fail;
    int          cyc;
    int          done_seen;
    logic        stop_low_seen;
    logic [63:0] count;
    logic        load_req;
    logic [63:0] preset_val;

    ringosc_meas_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .gate_cycles  (gate_cycles),
        .cnt_byte     (cnt_byte),
        .cnt_stop     (cnt_stop),
        .cnt_reset    (cnt_reset),
        .cnt_shift    (cnt_shift),
        .busy         (busy),
        .done         (done),
        .result_valid (result_valid),
        .result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc equals the number of rising edges so far
    always @(posedge clk) cyc <= cyc + 1;

    // Oscillator counter model: +3 per clk while running, cleared by cnt_reset
    always @(posedge clk) begin
        if (cnt_reset)      count <= '0;
        else if (load_req)  count <= preset_val;
        else if (!cnt_stop) count <= count + 64'd3;
    end

    always_comb cnt_byte = 8'(count >> cnt_shift);

    always @(negedge clk) if (!cnt_stop) stop_low_seen = 1'b1;

    // Done monitor: pop scoreboard and compare time, result and valid
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            done_seen = done_seen + 1;
            if (sb.size() == 0) begin
                n_checks = n_checks + 1;
                n_fail   = n_fail + 1;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                n_checks = n_checks + 3;
                if (cyc !== e.done_cyc) begin
                    n_fail = n_fail + 1;
                    $display("FAIL done_time got cycle %0d expected %0d", cyc, e.done_cyc);
                end
                if (result !== e.res) begin
                    n_fail = n_fail + 1;
                    $display("FAIL result got %h expected %h", result, e.res);
                end
                if (result_valid !== 1'b1) begin
                    n_fail = n_fail + 1;
                    $display("FAIL result_valid_at_done got %b expected 1", result_valid);
                end
            end
        end
    end

    // Drive one start pulse; returns the edge index that samples it
    task automatic launch(input logic [15:0] g, input logic expect_done,
                          input logic [63:0] exp_res, output int start_edge);
        exp_t e;
        @(negedge clk);
        gate_cycles = g;
        start       = 1'b1;
        start_edge  = cyc + 1;
        if (expect_done) begin
            e.res      = exp_res;
            e.done_cyc = start_edge + 2 + int'(g) + 4 + 24;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_checks = n_checks + 1;
            n_fail   = n_fail + 1;
            $display("FAIL drain_timeout pending %0d expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_until_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        n_checks = n_checks + 7;
        if (cnt_stop !== 1'b1)      begin n_fail++; $display("FAIL %s_cnt_stop got %b expected 1", tag, cnt_stop); end
        if (cnt_reset !== 1'b0)     begin n_fail++; $display("FAIL %s_cnt_reset got %b expected 0", tag, cnt_reset); end
        if (cnt_shift !== 6'd0)     begin n_fail++; $display("FAIL %s_cnt_shift got %0d expected 0", tag, cnt_shift); end
        if (busy !== 1'b0)          begin n_fail++; $display("FAIL %s_busy got %b expected 0", tag, busy); end
        if (done !== 1'b0)          begin n_fail++; $display("FAIL %s_done got %b expected 0", tag, done); end
        if (result_valid !== 1'b0)  begin n_fail++; $display("FAIL %s_result_valid got %b expected 0", tag, result_valid); end
        if (result !== 64'd0)       begin n_fail++; $display("FAIL %s_result got %h expected 0", tag, result); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_g100();
        int se;
        launch(16'd100, 1'b1, 64'd300, se);
        n_checks = n_checks + 2;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL g100_busy got %b expected 1", busy); end
        if (result_valid !== 1'b0) begin n_fail++; $display("FAIL g100_valid_cleared got %b expected 0", result_valid); end
        wait_drain(400);
        n_checks = n_checks + 3;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL g100_idle_busy got %b expected 0", busy); end
        if (result_valid !== 1'b1) begin n_fail++; $display("FAIL g100_valid_held got %b expected 1", result_valid); end
        if (result !== 64'd300) begin n_fail++; $display("FAIL g100_result_held got %0d expected 300", result); end
    endtask

    task automatic test_g0();
        int se;
        stop_low_seen = 1'b0;
        launch(16'd0, 1'b1, 64'd0, se);
        wait_drain(200);
        n_checks = n_checks + 1;
        if (stop_low_seen !== 1'b0) begin n_fail++; $display("FAIL g0_stop_low got %b expected 0", stop_low_seen); end
    endtask

    task automatic test_preset();
        int se;
        int n;
        preset_val = 64'h0123_4567_89AB_CDEF;
        launch(16'd0, 1'b1, 64'h0123_4567_89AB_CDEF, se);
        n = 0;
        while (!(busy && !cnt_reset) && n < 20) begin
            @(negedge clk);
            n++;
        end
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            n_checks = n_checks + 1;
            if (cnt_shift !== 6'(8 * (i / 3))) begin
                n_fail++;
                $display("FAIL preset_shift[%0d] got %0d expected %0d", i, cnt_shift, 8 * (i / 3));
            end
        end
        wait_drain(100);
    endtask

    task automatic test_restart_in_run();
        int se;
        int d0;
        d0 = done_seen;
        launch(16'd100, 1'b1, 64'd300, se);
        wait_until_cyc(se + 20);
        gate_cycles = 16'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain(400);
        repeat (40) @(negedge clk);
        n_checks = n_checks + 1;
        if (done_seen - d0 !== 1) begin n_fail++; $display("FAIL restart_done_count got %0d expected 1", done_seen - d0); end
    endtask

    task automatic test_abort();
        int se;
        int d0;
        d0 = done_seen;
        launch(16'd100, 1'b0, 64'd0, se);
        wait_until_cyc(se + 51);
        n_checks = n_checks + 1;
        if (cnt_stop !== 1'b0) begin n_fail++; $display("FAIL abort_in_run_stop got %b expected 0", cnt_stop); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks = n_checks + 4;
        if (busy !== 1'b0)         begin n_fail++; $display("FAIL abort_busy got %b expected 0", busy); end
        if (cnt_stop !== 1'b1)     begin n_fail++; $display("FAIL abort_stop got %b expected 1", cnt_stop); end
        if (result_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid got %b expected 0", result_valid); end
        if (done !== 1'b0)         begin n_fail++; $display("FAIL abort_done got %b expected 0", done); end
        repeat (150) @(negedge clk);
        n_checks = n_checks + 1;
        if (done_seen !== d0) begin n_fail++; $display("FAIL abort_no_done got %0d expected %0d", done_seen, d0); end
    endtask

    task automatic test_idle_abort();
        int se;
        launch(16'd3, 1'b1, 64'd9, se);
        wait_drain(100);
        n_checks = n_checks + 1;
        if (result_valid !== 1'b1) begin n_fail++; $display("FAIL idle_abort_pre_valid got %b expected 1", result_valid); end
        abort = 1'b1;
        start = 1'b1;
        gate_cycles = 16'd4;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        n_checks = n_checks + 3;
        if (result_valid !== 1'b0) begin n_fail++; $display("FAIL idle_abort_valid got %b expected 0", result_valid); end
        if (busy !== 1'b0)         begin n_fail++; $display("FAIL start_abort_busy got %b expected 0", busy); end
        if (result !== 64'd9)      begin n_fail++; $display("FAIL idle_abort_result got %0d expected 9", result); end
    endtask

    task automatic test_rst_mid();
        int se;
        int d0;
        d0 = done_seen;
        launch(16'd7, 1'b0, 64'd0, se);
        wait_until_cyc(se + 26);
        n_checks = n_checks + 1;
        if (cnt_shift !== 6'd32) begin n_fail++; $display("FAIL rst_mid_slot4_shift got %0d expected 32", cnt_shift); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("rst_mid");
        repeat (20) @(negedge clk);
        n_checks = n_checks + 1;
        if (done_seen !== d0) begin n_fail++; $display("FAIL rst_mid_no_done got %0d expected %0d", done_seen, d0); end
        launch(16'd10, 1'b1, 64'd30, se);
        wait_drain(200);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        cyc           = 0;
        done_seen     = 0;
        stop_low_seen = 1'b0;
        count         = '0;
        load_req      = 1'b0;
        preset_val    = '0;
        rst           = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        gate_cycles   = '0;

        test_reset();
        test_g100();
        test_g0();
        test_preset();
        test_restart_in_run();
        test_abort();
        test_idle_abort();
        test_rst_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
